// File: rtl/spwm_gate_sequencer.sv
// Three-phase SPWM gate sequencer: bootstrap precharge, dead-time protected run,
// stop ramp-down and latched fault shutdown in front of the gate-driver pins.
module spwm_gate_sequencer #(
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned BOOT_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fault_n,
  input  logic       fault_clr,
  input  logic       Va,
  input  logic       Vb,
  input  logic       Vc,
  output logic       ha,
  output logic       la,
  output logic       hb,
  output logic       lb,
  output logic       hc,
  output logic       lc,
  output logic [2:0] state,
  output logic       running,
  output logic       fault_latched
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StBoot   = 3'd1;
  localparam logic [2:0] StDeadIn = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StFault  = 3'd5;

  localparam logic [CNT_W-1:0] DeadLoad = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] BootLoad = CNT_W'(BOOT_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sx_q, cur_q, cur_d;
  logic [2:0]       gh_q, gh_d, gl_q, gl_d;
  logic [CNT_W-1:0] leg_cnt_q [3];
  logic [CNT_W-1:0] leg_cnt_d [3];

  // Sequencer FSM; one counter serves boot, entry dead time and stop dead time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!fault_n) begin
      state_d = StFault;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) begin
            state_d = StBoot;
            cnt_d   = BootLoad;
          end
        end
        StBoot: begin
          if (!enable) begin
            state_d = StStop;
            cnt_d   = DeadLoad;
          end else if (cnt_q <= CntOne) begin
            state_d = StDeadIn;
            cnt_d   = DeadLoad;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StDeadIn: begin
          if (!enable) begin
            state_d = StStop;
            cnt_d   = DeadLoad;
          end else if (cnt_q <= CntOne) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StRun: begin
          if (!enable) begin
            state_d = StStop;
            cnt_d   = DeadLoad;
          end
        end
        StStop: begin
          if (cnt_q <= CntOne) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StFault: begin
          if (fault_clr && !enable) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Per-leg commutation; gate values are computed from next-state so they register cleanly.
  always_comb begin
    gh_d = '0;
    gl_d = '0;
    for (int i = 0; i < 3; i++) begin
      cur_d[i]     = cur_q[i];
      leg_cnt_d[i] = leg_cnt_q[i];
      if (state_d != StRun) begin
        leg_cnt_d[i] = '0;
      end else if (state_q != StRun) begin
        cur_d[i]     = sx_q[i];
        leg_cnt_d[i] = '0;
      end else if (leg_cnt_q[i] != '0) begin
        leg_cnt_d[i] = leg_cnt_q[i] - CntOne;
        if (leg_cnt_q[i] == CntOne) begin
          cur_d[i] = sx_q[i];
        end
      end else if (sx_q[i] != cur_q[i]) begin
        leg_cnt_d[i] = DeadLoad;
      end

      if (state_d == StBoot) begin
        gl_d[i] = 1'b1;
      end else if (state_d == StRun && leg_cnt_d[i] == '0) begin
        gh_d[i] = cur_d[i];
        gl_d[i] = ~cur_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sx_q    <= '0;
      cur_q   <= '0;
      gh_q    <= '0;
      gl_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        leg_cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sx_q    <= {Vc, Vb, Va};
      cur_q   <= cur_d;
      gh_q    <= gh_d;
      gl_q    <= gl_d;
      for (int i = 0; i < 3; i++) begin
        leg_cnt_q[i] <= leg_cnt_d[i];
      end
    end
  end

  // fault_n gates the drivers directly so a fault removes them without waiting for a clock.
  assign ha = gh_q[0] & fault_n;
  assign la = gl_q[0] & fault_n;
  assign hb = gh_q[1] & fault_n;
  assign lb = gl_q[1] & fault_n;
  assign hc = gh_q[2] & fault_n;
  assign lc = gl_q[2] & fault_n;

  assign state         = state_q;
  assign running       = (state_q == StRun);
  assign fault_latched = (state_q == StFault);

endmodule

// File: doc/spwm_gate_sequencer.md
Name: spwm_gate_sequencer

Overview:
Sequences and protects the three-phase SPWM power stage. Takes the raw per-phase comparator commands (Va, Vb, Vc) and produces six dead-time-protected gate drives (high/low per leg). Runs the start-up (bootstrap precharge), run and stop sequence, and latches a fault shutdown. Sits between the comparators and the gate-driver pins.

Parameters:
DEAD_CYCLES, 8, clocks both switches of a leg are off on every commutation; legal range is 1 to 2^CNT_W-1.
BOOT_CYCLES, 1000, clocks all low-side switches are held on for bootstrap precharge; must be at least 1.
CNT_W, 16, width of the internal dead-time and boot counters.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  level; 1 requests run, 0 requests stop
fault_n  in  1  active-low external fault (overcurrent/desat)
fault_clr  in  1  single-cycle fault-latch clear request
Va, Vb, Vc  in  1 each  raw phase commands; 1 = high side, 0 = low side
ha, la, hb, lb, hc, lc  out  1 each  gate drives; 1 = switch on
state  out  3  FSM state: IDLE=0, BOOT=1, DEAD_IN=2, RUN=3, STOP=4, FAULT=5
running  out  1  1 only in RUN
fault_latched  out  1  1 only in FAULT

Behaviour:
- Reset (reset=0, asynchronous):
  - All gates 0, state=IDLE, running=0, fault_latched=0.
  - All counters and per-leg registers cleared.
  - Reset mid-operation forces all of these values immediately.
- Hard invariant: hX and lX are never both 1 in any cycle, in any state.
- Final gate outputs = registered gate value AND fault_n. A fault drops every gate combinationally, with zero clock latency.
- FSM, evaluated per rising edge:
  - FAULT has highest priority. fault_n=0 in any state causes FAULT at the next edge.
  - IDLE: all gates 0. enable=1 and fault_n=1 -> BOOT; load boot counter with BOOT_CYCLES.
  - BOOT: la=lb=lc=1, highs 0. Counter decrements; at 0 -> DEAD_IN, load DEAD_CYCLES.
    - enable=0 during BOOT -> STOP.
  - DEAD_IN: all gates 0 for DEAD_CYCLES clocks, then -> RUN.
    - On entry to RUN, each leg's applied command cur := the sampled Vx.
  - RUN: per-leg commutation logic (below).
    - enable=0 -> STOP.
  - STOP: all gates 0 for DEAD_CYCLES clocks, then -> IDLE.
  - FAULT: all gates 0, fault_latched=1.
    - Exit to IDLE only on a cycle with fault_clr=1, fault_n=1 and enable=0.
    - fault_clr is ignored outside FAULT, and ignored while fault_n=0 or enable=1.
- Per-leg commutation in RUN:
  - Vx is registered once (sx) before use.
  - Leg idle and sx == cur: hX = cur, lX = ~cur.
  - Leg idle and sx != cur, detected at edge t: both gates 0 from edge t; dead counter := DEAD_CYCLES.
  - At edge t+DEAD_CYCLES: cur := sx as sampled then; the corresponding gate turns on. The off gap is exactly DEAD_CYCLES clocks.
  - If sx toggles back during dead time, the leg still completes the full dead time, then applies the current sx, which may be the old side.
  - No commutation is started while a leg's counter is nonzero.
  - Legs are fully independent. Simultaneous commutations on all three legs are legal.
- Leaving RUN (STOP or FAULT) aborts any in-progress per-leg dead time. Per-leg counters are cleared.
- The boot counter is reloaded on every IDLE -> BOOT transition; there is no partial-resume.

Test Plan:
- Reset then enable=1 (DEAD_CYCLES=4, BOOT_CYCLES=10) -> state 0→1 with la=lb=lc=1 for 10 clocks → 2 with all gates 0 for 4 clocks → 3, running=1, gates follow Va/Vb/Vc.
- In RUN with Va=0 held (la=1), raise Va at edge t -> la=0 from edge t+1 (registered input), ha=0 until edge t+5, ha=1 thereafter; ha&la never 1.
- In RUN, Va pulses 1 for 2 clocks then returns to 0 -> la off for exactly 4 clocks then back on; ha never asserts.
- In RUN, drop fault_n to 0 mid-dead-time -> all six gates 0 in the same cycle; state=5 next edge.
  - Pulse fault_clr with enable=1 -> stays 5.
  - Pulse fault_clr with enable=0, fault_n=1 -> IDLE next edge.
- In RUN, enable=0 -> state 4, all gates 0 for 4 clocks, then 0.
  - Separately, enable=0 during BOOT -> STOP then IDLE.
- Assert reset=0 mid-RUN, asynchronously between edges -> all gates, running and state go to 0 immediately without a clock edge.
